// File: rtl/pcie_fc_pkg.sv
// Shared constants and FSM encoding for the PCIe flow-control tracker.
package pcie_fc_pkg;
  localparam int FC_STATE_W   = 3;
  localparam int FC_TH_HI_OFS = 1;  // default high threshold sits this far below DEPTH
  localparam int FC_TH_LO_DEF = 1;

  typedef enum logic [FC_STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } fc_state_e;
endpackage

// File: rtl/pcie_flow_ctrl_if.sv
// Bus bundle for pcie_flow_ctrl; err_cnt exists only when PCIE_FC_STATS_EN is defined.
interface pcie_flow_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4,
  parameter int TH_W   = 4
);
  logic                    init;
  logic [TH_W-1:0]         umbral_hi;
  logic [TH_W-1:0]         umbral_lo;
  logic [NUM_CH-1:0]       push;
  logic [NUM_CH-1:0]       pop;
  logic [NUM_CH-1:0]       pause;
  logic [NUM_CH*CNT_W-1:0] count_out;
  logic [NUM_CH-1:0]       ch_err;
  logic                    idle_out;
  logic                    active_out;
  logic                    error_out;
  logic [2:0]              state_out;
`ifdef PCIE_FC_STATS_EN
  logic [7:0]              err_cnt;
`endif

  modport master (
    output init, umbral_hi, umbral_lo, push, pop,
    input  pause, count_out, ch_err, idle_out, active_out, error_out, state_out
`ifdef PCIE_FC_STATS_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  init, umbral_hi, umbral_lo, push, pop,
    output pause, count_out, ch_err, idle_out, active_out, error_out, state_out
`ifdef PCIE_FC_STATS_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/fc_chan_counter.sv
// One channel: occupancy counter, pause hysteresis and sticky overflow/underflow flag.
module fc_chan_counter #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4,
  parameter int TH_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [TH_W-1:0]  i_th_hi,
  input  logic [TH_W-1:0]  i_th_lo,
  output logic [CNT_W-1:0] o_count,
  output logic             o_pause,
  output logic             o_ch_err,
  output logic             o_err_evt,
  output logic             o_push_ok,
  output logic             o_zero_nxt
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pause;
  logic             r_err;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf;
  logic             w_unf;

  always_comb begin
    w_full    = (r_cnt == CNT_W'(DEPTH));
    w_empty   = (r_cnt == '0);
    w_ovf     = i_push & ~i_pop & w_full;
    w_unf     = i_pop & ~i_push & w_empty;
    w_cnt_nxt = r_cnt;
    if (i_push & ~i_pop & ~w_full)      w_cnt_nxt = r_cnt + 1'b1;
    else if (i_pop & ~i_push & ~w_empty) w_cnt_nxt = r_cnt - 1'b1;
  end

  assign o_err_evt  = i_en & (w_ovf | w_unf);
  assign o_push_ok  = i_push & ~w_ovf;
  assign o_zero_nxt = (w_cnt_nxt == '0);
  assign o_count    = r_cnt;
  assign o_pause    = r_pause;
  assign o_ch_err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_pause <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_pause <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_en) begin
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_ovf | w_unf;
      // hysteresis acts on the occupancy already registered, hence one cycle behind it
      if (int'(r_cnt) >= int'(i_th_hi))      r_pause <= 1'b1;
      else if (int'(r_cnt) <= int'(i_th_lo)) r_pause <= 1'b0;
    end
  end
endmodule

// File: rtl/pcie_flow_ctrl.sv
// Per-channel credit/occupancy tracker with pause hysteresis and a global state machine.
// Define PCIE_FC_STATS_EN to add the saturating err_cnt output.
module pcie_flow_ctrl
  import pcie_fc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 8,
  parameter int TH_W      = 4,
  parameter int TH_HI_DEF = DEPTH - FC_TH_HI_OFS,
  parameter int TH_LO_DEF = FC_TH_LO_DEF
) (
  input logic             clk,
  input logic             reset,
  pcie_flow_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fc_state_e                    r_state, w_nxt;
  logic [TH_W-1:0]              r_th_hi, r_th_lo;
  int                           w_hi_int, w_lo_int;
  logic                         w_en, w_clr;
  logic [NUM_CH-1:0][CNT_W-1:0] w_count;
  logic [NUM_CH-1:0]            w_pause, w_ch_err, w_err_evt, w_push_ok, w_zero_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fc_chan_counter #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TH_W(TH_W)) u_cnt (
      .clk        (clk),
      .rst        (reset),
      .i_en       (w_en),
      .i_clr      (w_clr),
      .i_push     (bus.push[g]),
      .i_pop      (bus.pop[g]),
      .i_th_hi    (r_th_hi),
      .i_th_lo    (r_th_lo),
      .o_count    (w_count[g]),
      .o_pause    (w_pause[g]),
      .o_ch_err   (w_ch_err[g]),
      .o_err_evt  (w_err_evt[g]),
      .o_push_ok  (w_push_ok[g]),
      .o_zero_nxt (w_zero_nxt[g])
    );
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_RESET:  w_nxt = ST_INIT;
      ST_INIT:   if (!bus.init) w_nxt = ST_IDLE;
      ST_IDLE: begin
        if (|w_err_evt)      w_nxt = ST_ERROR;
        else if (bus.init)   w_nxt = ST_INIT;
        else if (|w_push_ok) w_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (|w_err_evt)      w_nxt = ST_ERROR;
        else if (&w_zero_nxt) w_nxt = ST_IDLE;
      end
      ST_ERROR:  if (bus.init) w_nxt = ST_INIT;
      default:   w_nxt = ST_RESET;
    endcase
  end

  // counters are wiped on the edge that enters (or stays in) INIT
  assign w_clr = (w_nxt == ST_INIT);
  assign w_en  = ((r_state == ST_IDLE) || (r_state == ST_ACTIVE)) && !w_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_hi_int = (int'(bus.umbral_hi) < 1) ? 1 : int'(bus.umbral_hi);
    if (w_hi_int > DEPTH) w_hi_int = DEPTH;
    w_lo_int = (int'(bus.umbral_lo) < w_hi_int) ? int'(bus.umbral_lo) : w_hi_int - 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th_hi <= TH_W'(TH_HI_DEF);
      r_th_lo <= TH_W'(TH_LO_DEF);
    end else if (r_state == ST_INIT && bus.init) begin
      r_th_hi <= TH_W'(w_hi_int);
      r_th_lo <= TH_W'(w_lo_int);
    end
  end

  assign bus.count_out  = w_count;
  assign bus.pause      = w_pause;
  assign bus.ch_err     = w_ch_err;
  assign bus.idle_out   = (r_state == ST_IDLE);
  assign bus.active_out = (r_state == ST_ACTIVE);
  assign bus.error_out  = (r_state == ST_ERROR);
  assign bus.state_out  = r_state;

`ifdef PCIE_FC_STATS_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err_cnt <= '0;
    else if (w_nxt == ST_ERROR && r_state != ST_ERROR && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_pcie_flow_ctrl.sv
// Directed bench for pcie_flow_ctrl: stimulus queues expected snapshots, a monitor compares them.
module tb_pcie_flow_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  typedef struct {
    int          cyc;
    string       nm;
    logic [2:0]  st;
    logic [15:0] cnt;
    logic [3:0]  ps;
    logic [3:0]  er;
    int          ec;
  } exp_t;
  exp_t q[$];

  pcie_flow_ctrl_if #(.NUM_CH(4), .CNT_W(4), .TH_W(4)) bus ();

  pcie_flow_ctrl #(.NUM_CH(4), .DEPTH(8), .TH_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] cv(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic cmp(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%0h exp=%0h", nm, what, act, exp);
    end
  endtask

  // expectation for the state after the next rising edge; returns at the following falling edge
  task automatic step(input string nm, input logic [2:0] st, input logic [15:0] cnt,
                      input logic [3:0] ps, input logic [3:0] er, input int ec);
    q.push_back('{cyc + 1, nm, st, cnt, ps, er, ec});
    @(negedge clk);
  endtask

  task automatic imm(input string nm, input logic [2:0] st, input logic [15:0] cnt,
                     input logic [3:0] ps, input logic [3:0] er, input int ec);
    q.push_back('{0, nm, st, cnt, ps, er, ec});
    ->chk_ev;
    #3;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        cmp(e.nm, "state", 32'(bus.state_out), 32'(e.st));
        cmp(e.nm, "count", 32'(bus.count_out), 32'(e.cnt));
        cmp(e.nm, "pause", 32'(bus.pause), 32'(e.ps));
        cmp(e.nm, "ch_err", 32'(bus.ch_err), 32'(e.er));
        cmp(e.nm, "flags", 32'({bus.idle_out, bus.active_out, bus.error_out}),
            32'({e.st == 3'd2, e.st == 3'd3, e.st == 3'd4}));
`ifdef PCIE_FC_STATS_EN
        cmp(e.nm, "err_cnt", 32'(bus.err_cnt), 32'(e.ec));
`endif
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.init = 1'b0; bus.umbral_hi = '0; bus.umbral_lo = '0;
    bus.push = '0;   bus.pop = '0;
    #2 imm("rst", 3'd0, 16'h0, 4'h0, 4'h0, 0);
    @(negedge clk);
    reset = 1'b0; bus.init = 1'b1; bus.umbral_hi = 4'd6; bus.umbral_lo = 4'd2;
    step("r2i", 3'd1, 16'h0, 4'h0, 4'h0, 0);
    step("init_hold", 3'd1, 16'h0, 4'h0, 4'h0, 0);
    bus.init = 1'b0;
    step("idle", 3'd2, 16'h0, 4'h0, 4'h0, 0);

    bus.push = 4'b0001;
    for (int k = 1; k <= 6; k++) step("push0", 3'd3, cv(k, 0, 0, 0), 4'h0, 4'h0, 0);
    bus.push = '0;
    step("pause_set", 3'd3, cv(6, 0, 0, 0), 4'b0001, 4'h0, 0);
    bus.pop = 4'b0001;
    for (int k = 1; k <= 4; k++) step("pop0", 3'd3, cv(6 - k, 0, 0, 0), 4'b0001, 4'h0, 0);
    bus.pop = '0;
    step("pause_clr", 3'd3, cv(2, 0, 0, 0), 4'h0, 4'h0, 0);

    bus.push = 4'b0010;
    for (int k = 1; k <= 8; k++)
      step("push1", 3'd3, cv(2, k, 0, 0), (k >= 7) ? 4'b0010 : 4'b0000, 4'h0, 0);
    bus.pop = 4'b0010;
    step("pp_full", 3'd3, cv(2, 8, 0, 0), 4'b0010, 4'h0, 0);
    bus.pop = '0;
    step("ovf", 3'd4, cv(2, 8, 0, 0), 4'b0010, 4'b0010, 1);
    bus.push = '0; bus.pop = 4'b0001;
    step("err_frz", 3'd4, cv(2, 8, 0, 0), 4'b0010, 4'b0010, 1);

    bus.pop = '0; bus.init = 1'b1; bus.umbral_hi = 4'd0; bus.umbral_lo = 4'd5;
    step("e2i", 3'd1, 16'h0, 4'h0, 4'h0, 1);
    step("cap_clamp", 3'd1, 16'h0, 4'h0, 4'h0, 1);
    bus.init = 1'b0;
    step("idle2", 3'd2, 16'h0, 4'h0, 4'h0, 1);
    bus.push = 4'b1000;
    step("th1_push", 3'd3, cv(0, 0, 0, 1), 4'h0, 4'h0, 1);
    bus.push = '0;
    step("th1_ps", 3'd3, cv(0, 0, 0, 1), 4'b1000, 4'h0, 1);
    bus.pop = 4'b1000;
    step("th1_pop", 3'd2, 16'h0, 4'b1000, 4'h0, 1);
    bus.pop = '0;
    step("th1_rel", 3'd2, 16'h0, 4'h0, 4'h0, 1);

    bus.pop = 4'b0100;
    step("unf", 3'd4, 16'h0, 4'h0, 4'b0100, 2);
    bus.pop = '0; bus.init = 1'b1; bus.umbral_hi = 4'd6; bus.umbral_lo = 4'd2;
    step("e2i_b", 3'd1, 16'h0, 4'h0, 4'h0, 2);
    step("cap_b", 3'd1, 16'h0, 4'h0, 4'h0, 2);
    bus.init = 1'b0;
    step("idle3", 3'd2, 16'h0, 4'h0, 4'h0, 2);

    bus.push = 4'b1011;
    step("mix1", 3'd3, cv(1, 1, 0, 1), 4'h0, 4'h0, 2);
    bus.push = 4'b0011;
    step("mix2", 3'd3, cv(2, 2, 0, 1), 4'h0, 4'h0, 2);
    step("mix3", 3'd3, cv(3, 3, 0, 1), 4'h0, 4'h0, 2);
    bus.push = 4'b0110; bus.pop = 4'b0100;
    step("pp_zero", 3'd3, cv(3, 4, 0, 1), 4'h0, 4'h0, 2);
    bus.push = 4'b0010; bus.pop = '0;
    step("mix5", 3'd3, cv(3, 5, 0, 1), 4'h0, 4'h0, 2);
    bus.push = '0;
    #2 reset = 1'b1;
    imm("async_rst", 3'd0, 16'h0, 4'h0, 4'h0, 0);
    @(negedge clk);
    reset = 1'b0;
    step("r2i_b", 3'd1, 16'h0, 4'h0, 4'h0, 0);
    step("idle4", 3'd2, 16'h0, 4'h0, 4'h0, 0);

    repeat (2) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s.unchecked got=pending exp=checked", e.nm);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
